// File: rtl/cs_micro_seq_pkg.sv
// cs_micro_seq_pkg: shared constants and instruction encoding for the micro-sequencer.
// Contents: AW_DEFAULT (micro-address width), instr_e (4-bit sequencer opcodes).
package cs_micro_seq_pkg;
  localparam int AW_DEFAULT = 13;
  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    LDCT = 4'd5,
    RFCT = 4'd6,
    CRTN = 4'd7,
    CONT = 4'd8
  } instr_e;
endpackage

// File: rtl/cs_ustack.sv
// cs_ustack: micro-return LIFO with clear, overwrite-on-full push and registered flags.
// Ports: clk_i, rst_n_i (async, active-low), push_i/pop_i/clr_i commands, din_i push data,
//        tos_o top entry (0 when empty), full_o/empty_o registered occupancy flags.
module cs_ustack #(
  parameter int DEPTH = 5,
  parameter int W     = 13
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clr_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] tos_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] TOP = SPW'(DEPTH);
  logic [W-1:0]   stk_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d, wr_idx;
  logic           full_q, empty_q;
  // A push onto a full stack rewrites the top slot rather than growing.
  assign wr_idx  = (sp_q == TOP) ? TOP - 1'b1 : sp_q;
  assign tos_o   = empty_q ? '0 : stk_q[sp_q - 1'b1];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  always_comb begin
    sp_d = sp_q;
    if (clr_i) sp_d = '0;
    else if (push_i) sp_d = (sp_q == TOP) ? sp_q : sp_q + 1'b1;
    else if (pop_i && sp_q != '0) sp_d = sp_q - 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      for (int k = 0; k < DEPTH; k++) stk_q[k] <= '0;
    end else begin
      sp_q    <= sp_d;
      full_q  <= (sp_d == TOP);
      empty_q <= (sp_d == '0);
      if (push_i && !clr_i) stk_q[wr_idx] <= din_i;
    end
  end
endmodule

// File: rtl/cs_micro_seq.sv
// cs_micro_seq: microprogram sequencer producing the next control-store address each cycle.
// Ports: CLK, RESET_n (async, active-low); INSTR opcode, CC_n/CCEN_n condition, D_12_0 branch/
//        count value, MAP_12_0 mapped entry, RLD_n counter reload; CSA_12_0 next address
//        (combinational), FULL_n/EMPTY registered return-stack status.
module cs_micro_seq
  import cs_micro_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 5,
  parameter int AW          = AW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic [3:0]    INSTR,
  input  logic          CC_n,
  input  logic          CCEN_n,
  input  logic [AW-1:0] D_12_0,
  input  logic [AW-1:0] MAP_12_0,
  input  logic          RLD_n,
  output logic [AW-1:0] CSA_12_0,
  output logic          FULL_n,
  output logic          EMPTY
);
  logic [AW-1:0] upc_q, upc_d, cnt_q, cnt_d, csa, tos;
  logic          pass, push, pop, clr, full;
  assign pass = CCEN_n | ~CC_n;
  always_comb begin
    csa   = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    cnt_d = cnt_q;
    case (INSTR)
      JZ:   begin csa = '0; clr = 1'b1; end
      CJS:  if (pass) begin csa = D_12_0; push = 1'b1; end
      JMAP: csa = MAP_12_0;
      CJP:  if (pass) csa = D_12_0;
      PUSH: begin push = 1'b1; if (pass) cnt_d = D_12_0; end
      LDCT: cnt_d = D_12_0;
      RFCT: if (cnt_q != '0) begin csa = tos; cnt_d = cnt_q - 1'b1; end else pop = 1'b1;
      CRTN: if (pass) begin csa = tos; pop = 1'b1; end
      default: ;
    endcase
    // External reload wins over any instruction-driven counter update.
    if (!RLD_n) cnt_d = D_12_0;
  end
  // Address is forced to zero for the whole reset window, independent of INSTR.
  assign CSA_12_0 = RESET_n ? csa : '0;
  assign upc_d    = CSA_12_0 + 1'b1;
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      upc_q <= '0;
      cnt_q <= '0;
    end else begin
      upc_q <= upc_d;
      cnt_q <= cnt_d;
    end
  end
  cs_ustack #(.DEPTH(STACK_DEPTH), .W(AW)) u_stack (
    .clk_i   (CLK),
    .rst_n_i (RESET_n),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .din_i   (upc_q),
    .tos_o   (tos),
    .full_o  (full),
    .empty_o (EMPTY)
  );
  assign FULL_n = ~full;
endmodule

// File: tb/tb_cs_micro_seq.sv
// tb_cs_micro_seq: scoreboard bench for cs_micro_seq.
module tb_cs_micro_seq;
  import cs_micro_seq_pkg::*;
  localparam int DEPTH = 5;
  typedef struct packed {logic [12:0] csa; logic full_n; logic empty;} obs_t;
  logic        CLK = 1'b0, RESET_n = 1'b0, CC_n = 1'b1, CCEN_n = 1'b1, RLD_n = 1'b1;
  logic [3:0]  INSTR = 4'd8;
  logic [12:0] D_12_0 = '0, MAP_12_0 = '0, CSA_12_0;
  logic        FULL_n, EMPTY;
  int          checks = 0, failures = 0;
  obs_t        exp_q[$], obs_q[$];
  logic [12:0] m_upc, m_cnt, m_stk[DEPTH];
  int          m_sp;
  logic        m_full_n, m_empty;

  cs_micro_seq #(.STACK_DEPTH(DEPTH), .AW(13)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .INSTR(INSTR), .CC_n(CC_n), .CCEN_n(CCEN_n),
    .D_12_0(D_12_0), .MAP_12_0(MAP_12_0), .RLD_n(RLD_n),
    .CSA_12_0(CSA_12_0), .FULL_n(FULL_n), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset;
    m_upc = '0; m_cnt = '0; m_sp = 0; m_full_n = 1'b1; m_empty = 1'b1;
    foreach (m_stk[k]) m_stk[k] = '0;
  endtask

  // One microcycle: drive, predict, sample at the falling edge, then advance the model.
  task automatic step(input logic [3:0] i, input logic cc = 1'b1, input logic ccen = 1'b1,
                      input logic [12:0] d = '0, input logic [12:0] mp = '0, input logic rld = 1'b1);
    logic pass, push, pop, clr;
    logic [12:0] csa, tos, ncnt;
    INSTR = i; CC_n = cc; CCEN_n = ccen; D_12_0 = d; MAP_12_0 = mp; RLD_n = rld;
    pass = ccen | ~cc;
    tos  = (m_sp > 0) ? m_stk[m_sp-1] : 13'd0;
    csa = m_upc; push = 0; pop = 0; clr = 0; ncnt = m_cnt;
    case (i)
      JZ:   begin csa = 0; clr = 1; end
      CJS:  if (pass) begin csa = d; push = 1; end
      JMAP: csa = mp;
      CJP:  if (pass) csa = d;
      PUSH: begin push = 1; if (pass) ncnt = d; end
      LDCT: ncnt = d;
      RFCT: if (m_cnt != 0) begin csa = tos; ncnt = m_cnt - 13'd1; end else pop = 1;
      CRTN: if (pass) begin csa = tos; pop = 1; end
      default: ;
    endcase
    if (!rld) ncnt = d;
    exp_q.push_back({csa, m_full_n, m_empty});
    #4 obs_q.push_back({CSA_12_0, FULL_n, EMPTY});
    @(posedge CLK);
    if (clr) m_sp = 0;
    else if (push) begin
      if (m_sp == DEPTH) m_stk[DEPTH-1] = m_upc;
      else begin m_stk[m_sp] = m_upc; m_sp++; end
    end else if (pop && m_sp > 0) m_sp--;
    m_full_n = (m_sp != DEPTH); m_empty = (m_sp == 0);
    m_cnt = ncnt; m_upc = csa + 13'd1;
    #1;
  endtask

  task automatic test_reset;
    INSTR = JMAP; MAP_12_0 = 13'h1234;
    #12;
    checks++; if (CSA_12_0 !== 13'h0) begin failures++; $display("FAIL reset_csa: got %h expected 0000", CSA_12_0); end
    checks++; if (FULL_n !== 1'b1) begin failures++; $display("FAIL reset_full_n: got %b expected 1", FULL_n); end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", EMPTY); end
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    model_reset();
  endtask

  task automatic test_cont;
    int n = 0;
    repeat (3) step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL cont[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      checks++; if (o.csa !== 13'(n) || o.empty !== 1'b1) begin failures++; $display("FAIL cont_const[%0d]: csa=%h empty=%b expected csa=%h empty=1", n, o.csa, o.empty, 13'(n)); end
      n++;
    end
  endtask

  task automatic test_cjs_crtn;
    int n = 0;
    step(CJP, 0, 0, 13'h0010);
    step(CJS, 0, 0, 13'h0400);
    step(CONT);
    step(CRTN, 1, 0);
    step(CRTN, 0, 0);
    step(CONT);
    step(CJS, 1, 0, 13'h0100);
    step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL cjs_crtn[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      if (n == 1) begin checks++; if (o.csa !== 13'h0400) begin failures++; $display("FAIL cjs_target: got %h expected 0400", o.csa); end end
      if (n == 4) begin checks++; if (o.csa !== 13'h0011) begin failures++; $display("FAIL crtn_return: got %h expected 0011", o.csa); end end
      if (n == 5) begin checks++; if (o.empty !== 1'b1) begin failures++; $display("FAIL crtn_empty: got %b expected 1", o.empty); end end
      n++;
    end
  endtask

  task automatic test_loop;
    int n = 0;
    logic [12:0] want [5];
    want[0] = 13'h20; want[1] = 13'h20; want[2] = 13'h20; want[3] = 13'h20; want[4] = 13'h21;
    step(CJP, 0, 0, 13'h001F);
    step(PUSH, 0, 0, 13'd3);
    repeat (4) step(RFCT);
    step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL loop[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      if (n >= 1 && n <= 5) begin checks++; if (o.csa !== want[n-1]) begin failures++; $display("FAIL loop_const[%0d]: got %h expected %h", n, o.csa, want[n-1]); end end
      if (n == 6) begin checks++; if (o.empty !== 1'b1) begin failures++; $display("FAIL loop_popped: empty=%b expected 1", o.empty); end end
      n++;
    end
  endtask

  task automatic test_stack_full;
    int n = 0;
    step(JZ);
    for (int k = 0; k < 6; k++) step(CJS, 0, 0, 13'((k + 1) << 8));
    step(CONT);
    repeat (6) step(CRTN, 0, 0);
    step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL stack_full[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      if (n == 5) begin checks++; if (o.full_n !== 1'b1) begin failures++; $display("FAIL full_after4: got %b expected 1", o.full_n); end end
      if (n == 6) begin checks++; if (o.full_n !== 1'b0) begin failures++; $display("FAIL full_after5: got %b expected 0", o.full_n); end end
      if (n == 8) begin checks++; if (o.csa !== 13'h0501) begin failures++; $display("FAIL overwrite_tos: got %h expected 0501", o.csa); end end
      if (n == 9) begin checks++; if (o.csa !== 13'h0301) begin failures++; $display("FAIL below_tos: got %h expected 0301", o.csa); end end
      if (n == 13) begin checks++; if (o.csa !== 13'h0000 || o.empty !== 1'b1) begin failures++; $display("FAIL pop_empty: csa=%h empty=%b expected 0000/1", o.csa, o.empty); end end
      n++;
    end
  endtask

  task automatic test_wrap;
    int n = 0;
    step(CJP, 1, 0, 13'h1FFF);
    step(CJP, 1, 1, 13'h1FFF);
    step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL wrap[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      if (n == 1) begin checks++; if (o.csa !== 13'h1FFF) begin failures++; $display("FAIL ccen_force: got %h expected 1fff", o.csa); end end
      if (n == 2) begin checks++; if (o.csa !== 13'h0000) begin failures++; $display("FAIL upc_wrap: got %h expected 0000", o.csa); end end
      n++;
    end
  endtask

  task automatic test_misc;
    int n = 0;
    step(JMAP, 1, 1, 13'h0, 13'h0ABC);
    step(4'd9);
    step(4'd15);
    step(JZ);
    step(PUSH, 1, 0, 13'd7);
    step(LDCT, 1, 1, 13'd1);
    step(RFCT, 1, 1, 13'd2, 13'h0, 1'b0);
    repeat (3) step(RFCT);
    step(CONT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL misc[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      if (n == 0) begin checks++; if (o.csa !== 13'h0ABC) begin failures++; $display("FAIL jmap: got %h expected 0abc", o.csa); end end
      n++;
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    step(PUSH, 0, 0, 13'd10);
    repeat (2) step(RFCT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL pre_reset[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      n++;
    end
    INSTR = RFCT;
    #2 RESET_n = 1'b0;
    #1;
    checks++; if (CSA_12_0 !== 13'h0) begin failures++; $display("FAIL async_csa: got %h expected 0000", CSA_12_0); end
    checks++; if (EMPTY !== 1'b1 || FULL_n !== 1'b1) begin failures++; $display("FAIL async_flags: empty=%b full_n=%b expected 1/1", EMPTY, FULL_n); end
    @(posedge CLK); #1;
    RESET_n = 1'b1;
    model_reset();
    n = 0;
    repeat (2) step(RFCT);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL post_reset[%0d]: csa=%h full_n=%b empty=%b expected csa=%h full_n=%b empty=%b", n, o.csa, o.full_n, o.empty, e.csa, e.full_n, e.empty); end
      checks++; if (o.csa !== 13'(n)) begin failures++; $display("FAIL post_reset_const[%0d]: got %h expected %h", n, o.csa, 13'(n)); end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_cont();
    test_cjs_crtn();
    test_loop();
    test_stack_full();
    test_wrap();
    test_misc();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
